// File: rtl/sdram_single_ctrl_if.sv
// sdram_single_ctrl_if
//   Request/response bus between an in-fabric initiator and the single-word
//   SDRAM controller.
//   sdram_req       : one-cycle request strobe (initiator -> controller)
//   sdram_addr[23:0]: [21:10] row, [9:2] column, [1:0] bank, [23:22] ignored
//   sdram_rh_wl     : 1 = read, 0 = write
//   sdram_data_w    : write data
//   sdram_ack       : one-cycle completion pulse (controller -> initiator)
//   sdram_data_r    : read data, held until the next read completes
//   sdram_data_r_en : read data valid, only ever high together with sdram_ack
interface sdram_single_ctrl_if;
  logic        sdram_req;
  logic [23:0] sdram_addr;
  logic        sdram_rh_wl;
  logic [15:0] sdram_data_w;
  logic        sdram_ack;
  logic [15:0] sdram_data_r;
  logic        sdram_data_r_en;

  modport master (
    output sdram_req, sdram_addr, sdram_rh_wl, sdram_data_w,
    input  sdram_ack, sdram_data_r, sdram_data_r_en
  );

  modport slave (
    input  sdram_req, sdram_addr, sdram_rh_wl, sdram_data_w,
    output sdram_ack, sdram_data_r, sdram_data_r_en
  );
endinterface

// File: rtl/sdram_single_ctrl.sv
// sdram_single_ctrl
//   Single-word controller for a 4-bank, 12-bit address, x16 SDRAM. Runs the
//   power-up sequence (NOP wait, PRECHARGE ALL, 2x AUTO REFRESH, LOAD MODE),
//   then turns each request into ACTIVE + READ/WRITE with auto-precharge.
//   Ports:
//     clk, reset_l      : system clock, asynchronous active-low reset
//     host (slave)      : request bus, see sdram_single_ctrl_if
//     zs_ck             : SDRAM clock (~clk, commands sampled mid-cycle)
//     zs_cke .. zs_we_n : registered SDRAM control pins
//     zs_ba/zs_addr/zs_dqm : registered SDRAM bank/address/mask pins
//     zs_dq             : data bus, driven only in the WRITE command cycle
//   Build option: define SDRAM_PERIODIC_REFRESH_EN to enable the periodic
//   auto-refresh counter; without it, REF is only issued during init.
module sdram_single_ctrl #(
  parameter int INIT_WAIT  = 10000,
  parameter int T_RP       = 2,
  parameter int T_RCD      = 2,
  parameter int T_RFC      = 4,
  parameter int T_MRD      = 2,
  parameter int T_WR       = 2,
  parameter int CAS_LAT    = 2,
  parameter int REF_PERIOD = 390
) (
  input  logic                clk,
  input  logic                reset_l,
  sdram_single_ctrl_if.slave  host,
  output logic                zs_ck,
  output logic                zs_cke,
  output logic                zs_cs_n,
  output logic                zs_ras_n,
  output logic                zs_cas_n,
  output logic                zs_we_n,
  output logic [1:0]          zs_ba,
  output logic [11:0]         zs_addr,
  output logic [1:0]          zs_dqm,
  inout  wire  [15:0]         zs_dq
);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int CW = ($clog2(INIT_WAIT + 1) > 4) ? $clog2(INIT_WAIT + 1) : 4;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_ACT, S_RD, S_WR, S_REF
  } state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]  cmd, cmd_nxt;
  logic [1:0]  ba_nxt, dqm_nxt;
  logic [11:0] addr_nxt;
  logic        dq_oe, dq_oe_nxt;
  logic        ack_nxt, rd_cap, ref_issue;

  // one-entry request slot, held until the access is acknowledged
  logic        slot_vld, slot_rd;
  logic [21:0] slot_addr;
  logic [15:0] slot_data;

  logic        ref_pending;
  logic        addr_unused;

  assign addr_unused = ^host.sdram_addr[23:22];
  assign zs_ck = ~clk;
  assign {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n} = cmd;
  assign zs_dq = dq_oe ? slot_data : 16'hzzzz;

`ifdef SDRAM_PERIODIC_REFRESH_EN
  localparam int RW = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
  logic [RW-1:0] ref_cnt;

  // Free-running once init is done, so the refresh cadence does not drift
  // when a REF has to wait for an access to finish.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (ref_issue) ref_pending <= 1'b0;
      if (state inside {S_IDLE, S_ACT, S_RD, S_WR, S_REF}) begin
        if (ref_cnt == RW'(REF_PERIOD - 1)) begin
          ref_cnt     <= '0;
          ref_pending <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic ref_unused;
  assign ref_pending = 1'b0;
  assign ref_unused  = ref_issue;
`endif

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      slot_vld  <= 1'b0;
      slot_rd   <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
    end else if (ack_nxt) begin
      slot_vld <= 1'b0;
    end else if (!slot_vld && host.sdram_req) begin
      slot_vld  <= 1'b1;
      slot_rd   <= host.sdram_rh_wl;
      slot_addr <= host.sdram_addr[21:0];
      slot_data <= host.sdram_data_w;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state                <= S_INIT_WAIT;
      cnt                  <= CW'(INIT_WAIT);
      cmd                  <= CMD_NOP;
      zs_cke               <= 1'b0;
      zs_ba                <= '0;
      zs_addr              <= '0;
      zs_dqm               <= '1;
      dq_oe                <= 1'b0;
      host.sdram_ack       <= 1'b0;
      host.sdram_data_r_en <= 1'b0;
      host.sdram_data_r    <= '0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      cmd                  <= cmd_nxt;
      zs_cke               <= 1'b1;
      zs_ba                <= ba_nxt;
      zs_addr              <= addr_nxt;
      zs_dqm               <= dqm_nxt;
      dq_oe                <= dq_oe_nxt;
      host.sdram_ack       <= ack_nxt;
      host.sdram_data_r_en <= rd_cap;
      if (rd_cap) host.sdram_data_r <= zs_dq;
    end
  end

  // Each state is entered with cnt = wait-1 and issues its exit command when
  // cnt reaches zero, so commands land exactly <wait> cycles apart.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - 1'b1;
    cmd_nxt   = CMD_NOP;
    ba_nxt    = zs_ba;
    addr_nxt  = zs_addr;
    dqm_nxt   = zs_dqm;
    dq_oe_nxt = 1'b0;
    ack_nxt   = 1'b0;
    rd_cap    = 1'b0;
    ref_issue = 1'b0;
    case (state)
      S_INIT_WAIT: if (cnt == '0) begin
        cmd_nxt   = CMD_PRE;
        addr_nxt  = 12'h400;
        state_nxt = S_INIT_PRE;
        cnt_nxt   = CW'(T_RP - 1);
      end
      S_INIT_PRE: if (cnt == '0) begin
        cmd_nxt   = CMD_REF;
        state_nxt = S_INIT_REF1;
        cnt_nxt   = CW'(T_RFC - 1);
      end
      S_INIT_REF1: if (cnt == '0) begin
        cmd_nxt   = CMD_REF;
        state_nxt = S_INIT_REF2;
        cnt_nxt   = CW'(T_RFC - 1);
      end
      S_INIT_REF2: if (cnt == '0) begin
        cmd_nxt   = CMD_MRS;
        ba_nxt    = 2'b00;
        addr_nxt  = {5'b00000, 3'(CAS_LAT), 4'b0000};
        state_nxt = S_INIT_MRS;
        cnt_nxt   = CW'(T_MRD - 1);
      end
      S_INIT_MRS: if (cnt == '0) begin
        dqm_nxt   = 2'b00;
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (ref_pending) begin
          cmd_nxt   = CMD_REF;
          ref_issue = 1'b1;
          state_nxt = S_REF;
          cnt_nxt   = CW'(T_RFC - 1);
        end else if (slot_vld) begin
          cmd_nxt   = CMD_ACT;
          ba_nxt    = slot_addr[1:0];
          addr_nxt  = slot_addr[21:10];
          state_nxt = S_ACT;
          cnt_nxt   = CW'(T_RCD - 1);
        end
      end
      S_ACT: if (cnt == '0) begin
        cmd_nxt   = slot_rd ? CMD_RD : CMD_WR;
        ba_nxt    = slot_addr[1:0];
        addr_nxt  = {4'b0100, slot_addr[9:2]};  // A10 = auto-precharge
        dq_oe_nxt = !slot_rd;
        state_nxt = slot_rd ? S_RD : S_WR;
        cnt_nxt   = slot_rd ? CW'(CAS_LAT) : CW'(T_WR + T_RP - 1);
      end
      S_RD: if (cnt == '0) begin
        rd_cap    = 1'b1;
        ack_nxt   = 1'b1;
        state_nxt = S_IDLE;
      end
      S_WR: if (cnt == '0) begin
        ack_nxt   = 1'b1;
        state_nxt = S_IDLE;
      end
      S_REF: if (cnt == '0) begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT_WAIT;
    endcase
  end

endmodule

// File: tb/tb_sdram_single_ctrl.sv
module tb_sdram_single_ctrl;
  localparam int INIT_WAIT  = 10000;
  localparam int T_RP       = 2;
  localparam int T_RCD      = 2;
  localparam int T_RFC      = 4;
  localparam int T_MRD      = 2;
  localparam int T_WR       = 2;
  localparam int CAS_LAT    = 2;
  localparam int REF_PERIOD = 390;
  localparam int RD_LAT     = 2 + T_RCD + CAS_LAT;
  localparam int WR_LAT     = 1 + T_RCD + T_WR + T_RP;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  sdram_single_ctrl_if bus();
  logic        zs_ck, zs_cke, zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n;
  logic [1:0]  zs_ba, zs_dqm;
  logic [11:0] zs_addr;
  wire  [15:0] zs_dq;
  logic [3:0]  cmd;
  assign cmd = {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n};

  sdram_single_ctrl #(
    .INIT_WAIT(INIT_WAIT), .T_RP(T_RP), .T_RCD(T_RCD), .T_RFC(T_RFC),
    .T_MRD(T_MRD), .T_WR(T_WR), .CAS_LAT(CAS_LAT), .REF_PERIOD(REF_PERIOD)
  ) dut (
    .clk(clk), .reset_l(reset_l), .host(bus),
    .zs_ck(zs_ck), .zs_cke(zs_cke), .zs_cs_n(zs_cs_n), .zs_ras_n(zs_ras_n),
    .zs_cas_n(zs_cas_n), .zs_we_n(zs_we_n), .zs_ba(zs_ba), .zs_addr(zs_addr),
    .zs_dqm(zs_dqm), .zs_dq(zs_dq)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SDRAM model (CAS latency 2, commands seen at zs_ck rise)
  logic [15:0] mem [logic [21:0]];
  logic [11:0] open_row [4];
  logic        v0 = 1'b0, v1 = 1'b0, mdl_en = 1'b0;
  logic [15:0] d0, d1, mdl_dq;
  logic [21:0] mkey;
  assign zs_dq = mdl_en ? mdl_dq : 16'hzzzz;

  always @(negedge clk) begin
    if (!reset_l) begin
      v0 = 1'b0; v1 = 1'b0; mdl_en = 1'b0;
    end else begin
      mdl_en = v1; mdl_dq = d1;
      v1 = v0; d1 = d0; v0 = 1'b0;
      mkey = {open_row[zs_ba], zs_addr[7:0], zs_ba};
      case (cmd)
        C_ACT: open_row[zs_ba] = zs_addr;
        C_RD: begin
          chk("rd_a10", zs_addr[10], 1);
          v0 = 1'b1;
          d0 = mem.exists(mkey) ? mem[mkey] : 16'h0000;
        end
        C_WR: begin
          chk("wr_a10", zs_addr[10], 1);
          mem[mkey] = zs_dq;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard
  typedef struct {
    bit          rd;
    logic [15:0] data;
    int          ack_cyc;
  } exp_t;
  exp_t q[$];
  logic [15:0] ref_mem [logic [21:0]];

  always @(negedge clk) begin
    exp_t e;
    if (reset_l) begin
      if (bus.sdram_ack || bus.sdram_data_r_en) begin
        if (q.size() == 0) begin
          chk("spurious_ack", bus.sdram_ack, 0);
        end else begin
          e = q.pop_front();
          chk("ack_with_r_en", bus.sdram_ack, 1);
          chk("data_r_en", bus.sdram_data_r_en, e.rd);
          if (e.rd) chk("read_data", bus.sdram_data_r, e.data);
          if (e.ack_cyc >= 0) begin
`ifdef SDRAM_PERIODIC_REFRESH_EN
            if (cyc == e.ack_cyc + T_RFC + 1) chk("ack_cycle", cyc, e.ack_cyc + T_RFC + 1);
            else chk("ack_cycle", cyc, e.ack_cyc);
`else
            chk("ack_cycle", cyc, e.ack_cyc);
`endif
          end
        end
      end else if (q.size() != 0 && q[0].ack_cyc >= 0 && cyc > q[0].ack_cyc + T_RFC + 1) begin
        chk("ack_missing", bus.sdram_ack, 1);
        void'(q.pop_front());
      end
    end
  end

  task automatic send(input bit rd, input logic [23:0] a, input logic [15:0] d,
                      input bit accept, input int extra);
    exp_t e;
    bus.sdram_req = 1'b1; bus.sdram_rh_wl = rd;
    bus.sdram_addr = a;   bus.sdram_data_w = d;
    if (accept) begin
      e.rd = rd;
      e.data = (rd && ref_mem.exists(a[21:0])) ? ref_mem[a[21:0]] : 16'h0000;
      e.ack_cyc = (extra < 0) ? -1 : cyc + 1 + (rd ? RD_LAT : WR_LAT) + extra;
      if (!rd) ref_mem[a[21:0]] = d;
      q.push_back(e);
    end
  endtask

  task automatic req_pulse(input bit rd, input logic [23:0] a, input logic [15:0] d,
                           input bit accept);
    send(rd, a, d, accept, 0);
    @(negedge clk);
    bus.sdram_req = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic wait_ack();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.sdram_ack && k < 50);
  endtask

  task automatic next_cmd(output logic [3:0] c, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (cmd == C_NOP && gap < 1000);
    c = cmd;
  endtask

  task automatic check_reset_vals();
    chk("rst_cke", zs_cke, 0);
    chk("rst_dqm", zs_dqm, 2'b11);
    chk("rst_cmd", cmd, C_NOP);
    chk("rst_ba", zs_ba, 0);
    chk("rst_addr", zs_addr, 0);
    chk("rst_ack", bus.sdram_ack, 0);
    chk("rst_r_en", bus.sdram_data_r_en, 0);
    chk("rst_data_r", bus.sdram_data_r, 0);
  endtask

  // called at the negedge where reset_l has just been released
  task automatic check_init(input bit with_req);
    int n = 0;
    int guard = 0;
    int gap;
    logic [3:0] c;
    while (cmd == C_NOP && guard < 2 * INIT_WAIT) begin
      @(negedge clk);
      guard++;
      if (zs_cke && cmd == C_NOP) n++;
      if (with_req && guard == 500) send(0, 24'h35A6B3, 16'hA5C3, 1, -1);
      if (with_req && guard == 501) bus.sdram_req = 1'b0;
    end
    chk("init_nop_cycles", n, INIT_WAIT);
    chk("init_pre", cmd, C_PRE);
    chk("init_pre_a10", zs_addr[10], 1);
    next_cmd(c, gap);
    chk("init_ref1", c, C_REF);
    chk("init_ref1_gap", gap, T_RP);
    next_cmd(c, gap);
    chk("init_ref2", c, C_REF);
    chk("init_ref2_gap", gap, T_RFC);
    next_cmd(c, gap);
    chk("init_mrs", c, C_MRS);
    chk("init_mrs_gap", gap, T_RFC);
    chk("init_mrs_addr", zs_addr, 12'h020);
    chk("init_mrs_dqm", zs_dqm, 2'b11);
    repeat (T_MRD) @(negedge clk);
    chk("init_dqm_open", zs_dqm, 2'b00);
    if (with_req) begin
      next_cmd(c, gap);
      chk("held_req_act", c, C_ACT);
      chk("held_req_act_gap", gap, 1);
    end
  endtask

  initial begin
    logic [3:0] c;
    int gap, n;
    bus.sdram_req = 1'b0; bus.sdram_addr = '0;
    bus.sdram_rh_wl = 1'b0; bus.sdram_data_w = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();

    // power-up with a request held across init
    reset_l = 1'b1;
    check_init(1);
    wait_drain(50);

    // write then read address 0
    req_pulse(0, 24'h000000, 16'hF055, 1);
    wait_drain(50);
    req_pulse(1, 24'h000000, 16'h0000, 1);
    wait_drain(50);

    // back-to-back: each request driven right after the previous ack;
    // the read uses different ignored upper address bits
    req_pulse(0, 24'hC007A5, 16'h3C96, 1);
    wait_ack();
    send(1, 24'h0007A5, 16'h0000, 1, 0);
    @(negedge clk); bus.sdram_req = 1'b0;
    wait_ack();
    send(1, 24'h35A6B3, 16'h0000, 1, 0);
    @(negedge clk); bus.sdram_req = 1'b0;
    wait_drain(50);

    // second request while busy is dropped
    req_pulse(1, 24'h000000, 16'h0000, 1);
    @(negedge clk);
    req_pulse(0, 24'h000000, 16'hDEAD, 0);
    wait_drain(50);
    repeat (10) @(negedge clk);
    req_pulse(1, 24'h000000, 16'h0000, 1);
    wait_drain(50);

`ifdef SDRAM_PERIODIC_REFRESH_EN
    // align to the refresh cadence while idle, then collide a request with it
    repeat (2) begin
      n = 0;
      do begin @(negedge clk); n++; end while (cmd != C_REF && n < 2 * REF_PERIOD);
    end
    chk("ref_seen", cmd, C_REF);
    repeat (REF_PERIOD - 2) @(posedge clk);
    @(negedge clk);
    send(1, 24'h0007A5, 16'h0000, 1, T_RFC + 1);
    @(negedge clk); bus.sdram_req = 1'b0;
    chk("ref_first", cmd, C_REF);
    next_cmd(c, gap);
    chk("act_after_ref", c, C_ACT);
    chk("act_after_ref_gap", gap, T_RFC + 1);
    wait_drain(50);
`else
    n = 0;
    repeat (5000) begin
      @(negedge clk);
      if (cmd == C_REF) n++;
    end
    chk("no_ref_issued", n, 0);
`endif

    // reset during the read CAS wait
    req_pulse(1, 24'h000000, 16'h0000, 0);
    n = 0;
    while (cmd != C_RD && n < 20) begin @(negedge clk); n++; end
    chk("rd_issued", cmd, C_RD);
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) @(negedge clk);
    chk("rst_hold_ack", bus.sdram_ack, 0);
    reset_l = 1'b1;
    check_init(0);
    repeat (10) @(negedge clk);
    chk("no_pending", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
